// File: rtl/fifo_bank.sv
// Bank of NUM_CH independent first-word-fall-through FIFOs with per-channel count and almost flags.
// Define FIFO_BANK_OVF_FLAG_EN to add the sticky per-channel ovf output.
module fifo_bank #(
  parameter int WORD_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int NUM_CH     = 4,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         clear,
  input  logic [NUM_CH-1:0]            in_valid,
  output logic [NUM_CH-1:0]            in_ready,
  input  logic [NUM_CH*WORD_WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]            out_valid,
  input  logic [NUM_CH-1:0]            out_ready,
  output logic [NUM_CH*WORD_WIDTH-1:0] out_data,
  output logic [NUM_CH*CNT_W-1:0]      count,
  output logic [NUM_CH-1:0]            almost_full,
`ifdef FIFO_BANK_OVF_FLAG_EN
  output logic [NUM_CH-1:0]            almost_empty,
  output logic [NUM_CH-1:0]            ovf
`else
  output logic [NUM_CH-1:0]            almost_empty
`endif
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [WORD_WIDTH-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0]      cnt;
    logic                  full, empty, push, pop;

    // Pointer MSB is the wrap phase: equal indices with differing phase means full.
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign cnt   = wr_ptr_q - rd_ptr_q;

    assign in_ready[c]  = !full && !clear;
    assign out_valid[c] = !empty && !clear;
    assign push         = in_valid[c] && in_ready[c];
    assign pop          = out_valid[c] && out_ready[c];

    assign count[c*CNT_W +: CNT_W]                = cnt;
    assign almost_full[c]                         = (cnt >= CNT_W'(AF_THRESH));
    assign almost_empty[c]                        = (cnt <= CNT_W'(AE_THRESH));
    assign out_data[c*WORD_WIDTH +: WORD_WIDTH]   = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (clear) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
      end else begin
        if (push) wr_ptr_d = wr_ptr_q + CNT_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
      end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= in_data[c*WORD_WIDTH +: WORD_WIDTH];
    end

`ifdef FIFO_BANK_OVF_FLAG_EN
    logic ovf_q, ovf_d;

    always_comb begin
      ovf_d = ovf_q;
      if (clear)                  ovf_d = 1'b0;
      else if (in_valid[c] && full) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) ovf_q <= 1'b0;
      else          ovf_q <= ovf_d;
    end

    assign ovf[c] = ovf_q;
`endif
  end

endmodule

// File: tb/tb_fifo_bank.sv
// Randomized scoreboard bench for fifo_bank: per-channel queues model occupancy, order and flags.
// Compile with FIFO_BANK_OVF_FLAG_EN defined to also exercise the ovf output.
module tb_fifo_bank;
  localparam int W  = 8;
  localparam int D  = 16;
  localparam int N  = 4;
  localparam int CW = 5;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           clear = 1'b0;
  logic [N-1:0]   in_valid = '0;
  logic [N-1:0]   in_ready;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   out_valid;
  logic [N-1:0]   out_ready = '0;
  logic [N*W-1:0] out_data;
  logic [N*CW-1:0] count;
  logic [N-1:0]   almost_full;
  logic [N-1:0]   almost_empty;
`ifdef FIFO_BANK_OVF_FLAG_EN
  logic [N-1:0]   ovf;
`endif

  always #5 clk = ~clk;

  fifo_bank #(.WORD_WIDTH(W), .DEPTH(D), .NUM_CH(N)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .almost_full(almost_full),
`ifdef FIFO_BANK_OVF_FLAG_EN
    .almost_empty(almost_empty), .ovf(ovf)
`else
    .almost_empty(almost_empty)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;
  logic [W-1:0] exp_q [N][$];
  logic [N-1:0] m_ovf = '0;

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s ch%0d: got %0h expected %0h at %0t", nm, c, act, exp, $time);
  endtask

  // Scoreboard: compare DUT against the queue model, then advance the model for the coming edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      for (int c = 0; c < N; c++) exp_q[c].delete();
      m_ovf = '0;
    end
    for (int c = 0; c < N; c++) begin
      int sz;
      sz = exp_q[c].size();
      chk("count", c, 32'(count[c*CW +: CW]), 32'(sz));
      chk("in_ready", c, 32'(in_ready[c]), 32'((sz < D) && !clear));
      chk("out_valid", c, 32'(out_valid[c]), 32'((sz > 0) && !clear));
      chk("almost_full", c, 32'(almost_full[c]), 32'(sz >= D - 2));
      chk("almost_empty", c, 32'(almost_empty[c]), 32'(sz <= 2));
`ifdef FIFO_BANK_OVF_FLAG_EN
      chk("ovf", c, 32'(ovf[c]), 32'(m_ovf[c]));
`endif
      if (reset_n) begin
        if (clear) begin
          exp_q[c].delete();
          m_ovf[c] = 1'b0;
        end else begin
          if (out_ready[c] && sz > 0) begin
            chk("out_data", c, 32'(out_data[c*W +: W]), 32'(exp_q[c][0]));
            void'(exp_q[c].pop_front());
          end
          if (in_valid[c]) begin
            if (sz < D) exp_q[c].push_back(in_data[c*W +: W]);
            else        m_ovf[c] = 1'b1;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int c, input logic [W-1:0] v);
    in_data[c*W +: W] = v;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_in_ready"}, 0, 32'(in_ready), 32'hF);
    chk({tag, "_out_valid"}, 0, 32'(out_valid), 32'h0);
    chk({tag, "_count"}, 0, 32'(count), 32'h0);
    chk({tag, "_almost_empty"}, 0, 32'(almost_empty), 32'hF);
    chk({tag, "_almost_full"}, 0, 32'(almost_full), 32'h0);
`ifdef FIFO_BANK_OVF_FLAG_EN
    chk({tag, "_ovf"}, 0, 32'(ovf), 32'h0);
`endif
  endtask

  initial begin
    #1;
    reset_checks("rst");
    step(); step();
    reset_n = 1'b1;
    step();

    // ch0: fill to full, one dropped push, then drain in order
    for (int i = 1; i <= 16; i++) begin
      in_valid[0] = 1'b1; set_data(0, W'(i)); step();
    end
    set_data(0, 8'hEE); step();
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    for (int i = 0; i < 17; i++) step();
    out_ready[0] = 1'b0;
    clear = 1'b1; step(); clear = 1'b0; step();

    // ch2: full, push+pop attempt pops only; then push+pop at 15
    for (int i = 0; i < 16; i++) begin
      in_valid[2] = 1'b1; set_data(2, W'($urandom)); step();
    end
    out_ready[2] = 1'b1; set_data(2, 8'h77); step();
    set_data(2, 8'h78); step();
    in_valid[2] = 1'b0;
    for (int i = 0; i < 17; i++) step();
    out_ready[2] = 1'b0;

    // ch1: single-word latency, then long random streaming to wrap pointers
    in_valid[1] = 1'b1; set_data(1, 8'hA5); step();
    in_valid[1] = 1'b0; out_ready[1] = 1'b1;
    chk("fwft_valid", 1, 32'(out_valid[1]), 32'h1);
    chk("fwft_data", 1, 32'(out_data[1*W +: W]), 32'hA5);
    step();
    for (int i = 0; i < 80; i++) begin
      in_valid[1]  = ($urandom_range(0, 9) < 8);
      out_ready[1] = ($urandom_range(0, 9) < 7);
      set_data(1, W'($urandom));
      step();
    end
    in_valid[1] = 1'b0; out_ready[1] = 1'b1;
    for (int i = 0; i < 17; i++) step();
    out_ready[1] = 1'b0;

    // ch3 holding 9 words (ch0 holding 3) flushed by clear with live handshakes
    for (int i = 0; i < 9; i++) begin
      in_valid[3] = 1'b1; set_data(3, W'($urandom));
      in_valid[0] = (i < 3); set_data(0, W'($urandom));
      step();
    end
    in_valid[0] = 1'b0;
    clear = 1'b1; out_ready[3] = 1'b1; step();
    clear = 1'b0; in_valid[3] = 1'b0; out_ready[3] = 1'b0;
    chk("clear_count3", 3, 32'(count[3*CW +: CW]), 32'h0);
    step();

    // all channels random, with occasional clear and one asynchronous reset mid-burst
    for (int i = 0; i < 300; i++) begin
      in_valid  = N'($urandom);
      out_ready = N'($urandom);
      in_data   = (N*W)'($urandom);
      clear     = ($urandom_range(0, 49) == 0);
      if (i == 150) begin
        #1 reset_n = 1'b0;
        #1 reset_checks("midrst");
        step();
        reset_n = 1'b1;
      end else begin
        step();
      end
    end
    in_valid = '0; clear = 1'b0; out_ready = '1;
    for (int i = 0; i < 18; i++) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
